apb_gpio: RTL and testbench
===========================

# apb_gpio

Parametrised APB3 GPIO peripheral: NUM_PINS bidirectional pins with per-pin direction, atomic set/clear, synchronised input sampling and per-pin level/edge interrupts. Sits on the APB bus as a slave alongside the memory-mapped slaves and drives a single `irq` line to the interrupt controller. Adds programmable wait states and PSLVERR reporting for illegal accesses.

## Interface
- NUM_PINS, 16, pin count, 1..32
- ADDR_WIDTH, 12, PADDR width in bits, byte addressing
- WAIT_STATES, 0, PREADY-low cycles inserted in every access phase, 0..3
- SYNC_STAGES, 2, input synchroniser depth, 2..3
- PCLK  in  1  clock; all logic on rising edge
- PRESETn  in  1  reset, asynchronous assert, active-low
- PADDR  in  ADDR_WIDTH  byte address
- PSEL, PENABLE, PWRITE  in  1 each  APB3 control
- PWDATA  in  32  write data
- PREADY  out  1  transfer complete
- PRDATA  out  32  read data
- PSLVERR  out  1  error, valid only with PREADY
- gpio_in  in  NUM_PINS  pad inputs, asynchronous
- gpio_out  out  NUM_PINS  pad output values (= DATA_OUT)
- gpio_oe  out  NUM_PINS  pad output enables (= DIR)
- irq  out  1  registered interrupt request

## Operation
- Register map, 32-bit words, bits above NUM_PINS read 0, ignored on write: 0x00 DATA_OUT RW; 0x04 DIR RW (1=output); 0x08 DATA_IN RO (synchronised pads); 0x0C IRQ_EN RW; 0x10 IRQ_TYPE RW (0=level, 1=edge); 0x14 IRQ_POL RW (1=high/rising, 0=low/falling); 0x18 IRQ_STATUS RW1C; 0x1C OUT_SET WO (DATA_OUT |= PWDATA); 0x20 OUT_CLR WO (DATA_OUT &= ~PWDATA).
- Reads of OUT_SET/OUT_CLR return 0, no error.
- PSLVERR=1 (no state change) on: PADDR[1:0]!=0, offset >0x20, write to DATA_IN.
- FSM: IDLE -> ACCESS at the edge where PSEL&!PENABLE (setup), wait counter loaded with WAIT_STATES. ACCESS: counter decrements each cycle while nonzero; transfer completes in the cycle PSEL&PENABLE&PREADY; next state IDLE. PSEL low in ACCESS -> IDLE, no write.
- Writes commit at the completing edge. Reads: PRDATA = addressed register in the PREADY cycle, 0 otherwise.
- Pin path: gpio_in -> SYNC_STAGES flops -> DATA_IN; prev register for edge detect. Detection runs on all pins regardless of DIR or IRQ_EN.
- Level mode: STATUS bit set every cycle DATA_IN==POL. Edge mode: set on selected edge of DATA_IN. Bits sticky until W1C.
- Same-cycle W1C and new event on a bit: set wins.
- irq <= |(IRQ_STATUS & IRQ_EN), registered.

## Timing
- Reset (async): all registers 0, FSM IDLE, PREADY=0, PRDATA=0, PSLVERR=0, gpio_out=0, gpio_oe=0, irq=0, sync chain 0.
- PREADY decoded from FSM state and counter only; no combinational path from APB inputs. Setup + WAIT_STATES+1 access cycles per transfer; back-to-back transfers sustained.
- Pad change before edge 0: DATA_IN updates at edge SYNC_STAGES; edge STATUS set at edge SYNC_STAGES+1; irq at edge SYNC_STAGES+2.
- Register write affects gpio_out/gpio_oe the cycle after the completing edge.
- Reset mid-transfer: transfer aborted, no write, FSM IDLE on release.

## Structure
- Package apb_gpio_pkg: register offset constants, FSM state enum, IRQ_TYPE/POL encodings.
- Sub-module gpio_sync_edge: per-pin synchroniser plus rise/fall pulse outputs, instantiated once with width NUM_PINS.

## Test plan
- Reset release: all outputs 0; read 0x04 returns 0x0000_0000, PREADY after 1 access cycle (WAIT_STATES=0).
- Write 0x0000_00FF to DIR, 0x0000_A5A5 to DATA_OUT, OUT_CLR 0x0000_0005, OUT_SET 0x0000_0100 -> gpio_oe=0x00FF, gpio_out=0xA5A0, then 0xA5A0|0x0100=0xA5A0? use 0xA5A0 -> 0xA5A0|0x0100 = 0xA5A0 (bit8 already set); verify readback 0xA5A0.
- WAIT_STATES=2: every access shows PREADY low for 2 access cycles then high 1 cycle; PRDATA valid only then.
- Edge IRQ pin 3 rising, IRQ_EN=0x8: drive gpio_in[3] 0->1 -> STATUS=0x8 at edge SYNC_STAGES+1, irq high next edge; W1C 0x8 -> irq low 2 cycles later.
- Level IRQ pin 0 low-active held low: W1C clears then STATUS re-sets next cycle; simultaneous edge event and W1C on same bit leaves bit set.
- Write 0x08, read 0x24, read 0x02 -> PSLVERR=1 with PREADY, no register change; PRESETn pulsed mid-access -> all outputs 0, no write.

Source files
------------

// File: rtl/apb_gpio_pkg.sv
// ----------------------------------------------------------------------------
// apb_gpio_pkg
// Shared definitions for the APB GPIO peripheral:
//   - byte offsets of every register in the 0x00..0x20 window
//   - APB slave FSM state encoding
//   - per-pin encodings of the IRQ_TYPE and IRQ_POL registers
// No ports; imported by apb_gpio.
// ----------------------------------------------------------------------------
package apb_gpio_pkg;

    // Register byte offsets (only PADDR[5:0] is decoded once the range check passes)
    localparam logic [5:0] OFF_DATA_OUT   = 6'h00;
    localparam logic [5:0] OFF_DIR        = 6'h04;
    localparam logic [5:0] OFF_DATA_IN    = 6'h08;
    localparam logic [5:0] OFF_IRQ_EN     = 6'h0C;
    localparam logic [5:0] OFF_IRQ_TYPE   = 6'h10;
    localparam logic [5:0] OFF_IRQ_POL    = 6'h14;
    localparam logic [5:0] OFF_IRQ_STATUS = 6'h18;
    localparam logic [5:0] OFF_OUT_SET    = 6'h1C;
    localparam logic [5:0] OFF_OUT_CLR    = 6'h20;

    // APB slave states: IDLE waits for a setup phase, ACCESS holds until PREADY
    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } apb_state_e;

    // IRQ_TYPE bit encoding
    localparam logic IRQ_TYPE_LEVEL = 1'b0;
    localparam logic IRQ_TYPE_EDGE  = 1'b1;

    // IRQ_POL bit encoding (high level / rising edge vs low level / falling edge)
    localparam logic IRQ_POL_LOW    = 1'b0;
    localparam logic IRQ_POL_HIGH   = 1'b1;

endpackage

// File: rtl/gpio_sync_edge.sv
// ----------------------------------------------------------------------------
// gpio_sync_edge
// Multi-flop synchroniser for asynchronous pad inputs, followed by a
// "previous value" register so single-cycle rise/fall pulses can be derived.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset, clears the chain and prev
//   async_in  in   WIDTH raw pad inputs
//   sync_out  out  WIDTH synchronised values (last flop of the chain)
//   rise      out  WIDTH one-cycle pulses, sync_out went 0->1
//   fall      out  WIDTH one-cycle pulses, sync_out went 1->0
// ----------------------------------------------------------------------------
module gpio_sync_edge #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] chain [STAGES];
    logic [WIDTH-1:0] prev;

    // Shift the pads through STAGES flops; prev trails the synchronised value
    // by one cycle so edges are seen exactly once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                chain[s] <= '0;
            end
            prev <= '0;
        end else begin
            chain[0] <= async_in;
            for (int s = 1; s < STAGES; s++) begin
                chain[s] <= chain[s-1];
            end
            prev <= chain[STAGES-1];
        end
    end

    assign sync_out = chain[STAGES-1];
    assign rise     = sync_out & ~prev;
    assign fall     = ~sync_out & prev;

endmodule

// File: rtl/apb_gpio.sv
// ----------------------------------------------------------------------------
// apb_gpio
// APB3 slave GPIO block: NUM_PINS pins with direction, atomic set/clear,
// synchronised input sampling and per-pin level/edge interrupts.
// Ports:
//   PCLK, PRESETn          clock / async active-low reset
//   PADDR, PSEL, PENABLE,
//   PWRITE, PWDATA         APB3 request
//   PREADY, PRDATA, PSLVERR APB3 response (PREADY from FSM state only)
//   gpio_in                asynchronous pad inputs
//   gpio_out, gpio_oe      pad output values (DATA_OUT) and enables (DIR)
//   irq                    registered OR of enabled pending status bits
// ----------------------------------------------------------------------------
module apb_gpio
    import apb_gpio_pkg::*;
#(
    parameter int NUM_PINS    = 16,
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [31:0]           PWDATA,
    output logic                  PREADY,
    output logic [31:0]           PRDATA,
    output logic                  PSLVERR,
    input  logic [NUM_PINS-1:0]   gpio_in,
    output logic [NUM_PINS-1:0]   gpio_out,
    output logic [NUM_PINS-1:0]   gpio_oe,
    output logic                  irq
);

    localparam logic [1:0] WAIT_LOAD = 2'(WAIT_STATES);

    apb_state_e state, next_state;
    logic [1:0] wait_cnt, next_wait_cnt;

    logic [NUM_PINS-1:0] data_out, dir, irq_en, irq_type, irq_pol, irq_status;
    logic [NUM_PINS-1:0] data_in, pin_rise, pin_fall, irq_event, w1c_mask, rd_sel;
    logic [NUM_PINS-1:0] wdata;
    logic [31:0]         rd_word;
    logic [5:0]          offset;
    logic                addr_err, xfer_done, wr_en;
    logic                unused_pwdata;

    assign offset        = PADDR[5:0];
    assign wdata         = PWDATA[NUM_PINS-1:0];
    assign unused_pwdata = ^PWDATA;

    // Pad synchroniser and edge detector shared by all pins
    gpio_sync_edge #(
        .WIDTH  (NUM_PINS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .async_in (gpio_in),
        .sync_out (data_in),
        .rise     (pin_rise),
        .fall     (pin_fall)
    );

    // FSM state and wait-state counter registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= ST_IDLE;
            wait_cnt <= 2'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait_cnt;
        end
    end

    // Next-state logic; PREADY depends only on state and counter so there is
    // no combinational path from the APB inputs to PREADY.
    always_comb begin
        next_state    = state;
        next_wait_cnt = wait_cnt;
        PREADY        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    next_state    = ST_ACCESS;
                    next_wait_cnt = WAIT_LOAD;
                end
            end
            ST_ACCESS: begin
                PREADY = (wait_cnt == 2'd0);
                if (!PSEL) begin
                    next_state = ST_IDLE;
                end else if (PENABLE && (wait_cnt == 2'd0)) begin
                    next_state = ST_IDLE;
                end else if (wait_cnt != 2'd0) begin
                    next_wait_cnt = wait_cnt - 2'd1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Illegal accesses: misaligned, beyond OUT_CLR, or a write to DATA_IN.
    // Once PADDR <= 0x20 is known, offset == 0x08 identifies DATA_IN exactly.
    assign addr_err  = (PADDR[1:0] != 2'b00)
                     || (PADDR > ADDR_WIDTH'(OFF_OUT_CLR))
                     || (PWRITE && (offset == OFF_DATA_IN));
    assign xfer_done = (state == ST_ACCESS) && PSEL && PENABLE && PREADY;
    assign wr_en     = xfer_done && PWRITE && !addr_err;

    // Read mux; write-only registers and unmapped bits read as zero
    always_comb begin
        rd_sel = '0;
        case (offset)
            OFF_DATA_OUT:   rd_sel = data_out;
            OFF_DIR:        rd_sel = dir;
            OFF_DATA_IN:    rd_sel = data_in;
            OFF_IRQ_EN:     rd_sel = irq_en;
            OFF_IRQ_TYPE:   rd_sel = irq_type;
            OFF_IRQ_POL:    rd_sel = irq_pol;
            OFF_IRQ_STATUS: rd_sel = irq_status;
            default:        rd_sel = '0;
        endcase
        rd_word = '0;
        rd_word[NUM_PINS-1:0] = rd_sel;
    end

    assign PRDATA  = (PREADY && !PWRITE && !addr_err) ? rd_word : 32'h0;
    assign PSLVERR = PREADY && addr_err;

    // Control registers commit on the completing edge of a legal write
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            data_out <= '0;
            dir      <= '0;
            irq_en   <= '0;
            irq_type <= '0;
            irq_pol  <= '0;
        end else if (wr_en) begin
            case (offset)
                OFF_DATA_OUT: data_out <= wdata;
                OFF_DIR:      dir      <= wdata;
                OFF_IRQ_EN:   irq_en   <= wdata;
                OFF_IRQ_TYPE: irq_type <= wdata;
                OFF_IRQ_POL:  irq_pol  <= wdata;
                OFF_OUT_SET:  data_out <= data_out | wdata;
                OFF_OUT_CLR:  data_out <= data_out & ~wdata;
                default:      ;
            endcase
        end
    end

    // Per-pin interrupt event; runs on every pin regardless of DIR or IRQ_EN
    always_comb begin
        irq_event = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            case (irq_type[i])
                IRQ_TYPE_EDGE:  irq_event[i] = (irq_pol[i] == IRQ_POL_HIGH) ? pin_rise[i] : pin_fall[i];
                IRQ_TYPE_LEVEL: irq_event[i] = (irq_pol[i] == IRQ_POL_LOW) ? !data_in[i] : data_in[i];
                default:        irq_event[i] = 1'b0;
            endcase
        end
    end

    assign w1c_mask = (wr_en && (offset == OFF_IRQ_STATUS)) ? wdata : '0;

    // Sticky status; a new event in the same cycle as its W1C keeps the bit set
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq_status <= '0;
        end else begin
            irq_status <= (irq_status & ~w1c_mask) | irq_event;
        end
    end

    // Registered interrupt request
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq <= 1'b0;
        end else begin
            irq <= |(irq_status & irq_en);
        end
    end

    assign gpio_out = data_out;
    assign gpio_oe  = dir;

endmodule

// File: tb/tb_apb_gpio.sv
// ----------------------------------------------------------------------------
// tb_apb_gpio
// Directed bench for apb_gpio. Two instances share the APB address/data
// wires: dut0 with no wait states and dut2 with two. Each bus transfer pushes
// its expected PRDATA/PSLVERR onto a queue; an independent monitor pops and
// compares whenever a selected slave completes a transfer.
// ----------------------------------------------------------------------------
module tb_apb_gpio;

    localparam logic [11:0] A_DATA_OUT   = 12'h000;
    localparam logic [11:0] A_DIR        = 12'h004;
    localparam logic [11:0] A_DATA_IN    = 12'h008;
    localparam logic [11:0] A_IRQ_EN     = 12'h00C;
    localparam logic [11:0] A_IRQ_TYPE   = 12'h010;
    localparam logic [11:0] A_IRQ_POL    = 12'h014;
    localparam logic [11:0] A_IRQ_STATUS = 12'h018;
    localparam logic [11:0] A_OUT_SET    = 12'h01C;
    localparam logic [11:0] A_OUT_CLR    = 12'h020;

    typedef struct packed {
        logic        ws;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [11:0] paddr;
    logic        psel0, psel2, penable, pwrite;
    logic [31:0] pwdata;
    logic        pready0, pslverr0, irq0, pready2, pslverr2, irq2;
    logic [31:0] prdata0, prdata2;
    logic [15:0] gpio_in0, gpio_out0, gpio_oe0;
    logic [15:0] gpio_in2, gpio_out2, gpio_oe2;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vec_count  = 0;
    int   miss_count = 0;

    assign gpio_in2 = 16'h0000;

    always #5 PCLK = ~PCLK;

    apb_gpio #(.NUM_PINS(16), .ADDR_WIDTH(12), .WAIT_STATES(0), .SYNC_STAGES(2)) dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(paddr), .PSEL(psel0),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
        .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0),
        .gpio_in(gpio_in0), .gpio_out(gpio_out0), .gpio_oe(gpio_oe0), .irq(irq0)
    );

    apb_gpio #(.NUM_PINS(16), .ADDR_WIDTH(12), .WAIT_STATES(2), .SYNC_STAGES(2)) dut2 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(paddr), .PSEL(psel2),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
        .PREADY(pready2), .PRDATA(prdata2), .PSLVERR(pslverr2),
        .gpio_in(gpio_in2), .gpio_out(gpio_out2), .gpio_oe(gpio_oe2), .irq(irq2)
    );

    // One comparison: counts it and reports a mismatch
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // One APB transfer starting at posedge+1; leaves the bus idle at posedge+1
    // after the completing edge, so consecutive calls run back-to-back.
    task automatic applyStimulus(input logic ws, input logic wr, input logic [11:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                 input logic exp_err);
        exp_t item;
        int   waits;
        bit   done;
        item.ws    = ws;
        item.rdata = exp_rdata;
        item.err   = exp_err;
        sb_q.push_back(item);
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wdata;
        penable = 1'b0;
        if (ws) psel2 = 1'b1;
        else    psel0 = 1'b1;
        @(posedge PCLK); #1;
        penable = 1'b1;
        waits = 0;
        done  = 1'b0;
        while (!done && waits <= 8) begin
            @(negedge PCLK);
            if (ws ? pready2 : pready0) begin
                done = 1'b1;
            end else begin
                waits++;
                if (ws) checkOutput("prdata_in_wait", prdata2, 32'h0);
            end
        end
        if (!done) begin
            vec_count++;
            miss_count++;
            $display("[TB] FAIL pready_timeout: got no PREADY, expected PREADY for addr 0x%03h", addr);
            void'(sb_q.pop_back());
        end
        checkOutput(ws ? "wait_cycles_ws2" : "wait_cycles_ws0", 32'(waits), ws ? 32'd2 : 32'd0);
        @(posedge PCLK); #1;
        psel0   = 1'b0;
        psel2   = 1'b0;
        penable = 1'b0;
    endtask

    task automatic bus_write(input logic ws, input logic [11:0] addr, input logic [31:0] data, input logic err);
        applyStimulus(ws, 1'b1, addr, data, 32'h0, err);
    endtask

    task automatic bus_read(input logic ws, input logic [11:0] addr, input logic [31:0] exp, input logic err);
        applyStimulus(ws, 1'b0, addr, 32'h0, exp, err);
    endtask

    // Scoreboard monitor: pops an expectation at every completing access phase
    always @(negedge PCLK) begin
        if (penable && ((psel0 && pready0) || (psel2 && pready2))) begin
            if (sb_q.size() == 0) begin
                vec_count++;
                miss_count++;
                $display("[TB] FAIL unexpected_response: got a completion, expected none");
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("prdata",  mon_e.ws ? prdata2 : prdata0, mon_e.rdata);
                checkOutput("pslverr", 32'(mon_e.ws ? pslverr2 : pslverr0), 32'(mon_e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        PRESETn  = 1'b0;
        psel0    = 1'b0;
        psel2    = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = 12'h0;
        pwdata   = 32'h0;
        gpio_in0 = 16'h0000;

        // Reset values
        repeat (3) @(posedge PCLK);
        #1;
        checkOutput("rst_pready",   32'(pready0),  32'h0);
        checkOutput("rst_prdata",   prdata0,       32'h0);
        checkOutput("rst_pslverr",  32'(pslverr0), 32'h0);
        checkOutput("rst_gpio_out", 32'(gpio_out0), 32'h0);
        checkOutput("rst_gpio_oe",  32'(gpio_oe0), 32'h0);
        checkOutput("rst_irq",      32'(irq0),     32'h0);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        bus_read(1'b0, A_DIR, 32'h0, 1'b0);

        // Direction, data out, atomic set/clear
        bus_write(1'b0, A_DIR, 32'hFFFF_00FF, 1'b0);
        checkOutput("gpio_oe", 32'(gpio_oe0), 32'h0000_00FF);
        bus_read(1'b0, A_DIR, 32'h0000_00FF, 1'b0);
        bus_write(1'b0, A_DATA_OUT, 32'h0000_A5A5, 1'b0);
        checkOutput("gpio_out_wr", 32'(gpio_out0), 32'h0000_A5A5);
        bus_write(1'b0, A_OUT_CLR, 32'h0000_0005, 1'b0);
        checkOutput("gpio_out_clr", 32'(gpio_out0), 32'h0000_A5A0);
        bus_write(1'b0, A_OUT_SET, 32'h0000_0100, 1'b0);
        checkOutput("gpio_out_set8", 32'(gpio_out0), 32'h0000_A5A0);
        bus_write(1'b0, A_OUT_SET, 32'h0000_0002, 1'b0);
        checkOutput("gpio_out_set1", 32'(gpio_out0), 32'h0000_A5A2);
        bus_write(1'b0, A_OUT_CLR, 32'h0000_0002, 1'b0);
        checkOutput("gpio_out_clr1", 32'(gpio_out0), 32'h0000_A5A0);
        bus_read(1'b0, A_DATA_OUT, 32'h0000_A5A0, 1'b0);
        bus_read(1'b0, A_OUT_SET, 32'h0, 1'b0);
        bus_read(1'b0, A_OUT_CLR, 32'h0, 1'b0);
        bus_read(1'b0, A_DATA_IN, 32'h0, 1'b0);

        // Illegal accesses leave state untouched
        bus_write(1'b0, A_DATA_IN, 32'h0000_FFFF, 1'b1);
        bus_read(1'b0, 12'h024, 32'h0, 1'b1);
        bus_read(1'b0, 12'h002, 32'h0, 1'b1);
        bus_write(1'b0, 12'h001, 32'h0, 1'b1);
        bus_write(1'b0, 12'h040, 32'h0, 1'b1);
        checkOutput("gpio_out_after_err", 32'(gpio_out0), 32'h0000_A5A0);
        bus_read(1'b0, A_DATA_OUT, 32'h0000_A5A0, 1'b0);
        bus_read(1'b0, A_DIR, 32'h0000_00FF, 1'b0);

        // Edge interrupt on pin 3, rising; pin 0 stays level-low
        bus_write(1'b0, A_IRQ_TYPE, 32'h0000_FFFE, 1'b0);
        bus_write(1'b0, A_IRQ_POL, 32'h0000_0008, 1'b0);
        bus_write(1'b0, A_IRQ_STATUS, 32'h0000_FFFF, 1'b0);
        bus_read(1'b0, A_IRQ_STATUS, 32'h0000_0001, 1'b0);
        bus_write(1'b0, A_IRQ_EN, 32'h0000_0008, 1'b0);
        checkOutput("irq_idle", 32'(irq0), 32'h0);
        gpio_in0[3] = 1'b1;
        repeat (3) begin
            @(posedge PCLK); #1;
        end
        checkOutput("irq_before_edge4", 32'(irq0), 32'h0);
        @(posedge PCLK); #1;
        checkOutput("irq_at_edge4", 32'(irq0), 32'h1);
        bus_read(1'b0, A_DATA_IN, 32'h0000_0008, 1'b0);
        bus_read(1'b0, A_IRQ_STATUS, 32'h0000_0009, 1'b0);
        bus_write(1'b0, A_IRQ_STATUS, 32'h0000_0008, 1'b0);
        checkOutput("irq_hold_after_w1c", 32'(irq0), 32'h1);
        @(posedge PCLK); #1;
        checkOutput("irq_clear_after_w1c", 32'(irq0), 32'h0);

        // Rising edge lands on the same edge as its W1C: set wins
        gpio_in0[3] = 1'b0;
        repeat (4) begin
            @(posedge PCLK); #1;
        end
        gpio_in0[3] = 1'b1;
        @(posedge PCLK); #1;
        bus_write(1'b0, A_IRQ_STATUS, 32'h0000_0008, 1'b0);
        bus_read(1'b0, A_IRQ_STATUS, 32'h0000_0009, 1'b0);
        checkOutput("irq_after_collision", 32'(irq0), 32'h1);
        bus_write(1'b0, A_IRQ_STATUS, 32'h0000_0008, 1'b0);
        bus_read(1'b0, A_IRQ_STATUS, 32'h0000_0001, 1'b0);

        // Level-low pin 0 re-asserts after W1C; switching to high polarity stops it
        bus_write(1'b0, A_IRQ_STATUS, 32'h0000_0001, 1'b0);
        bus_read(1'b0, A_IRQ_STATUS, 32'h0000_0001, 1'b0);
        bus_write(1'b0, A_IRQ_POL, 32'h0000_0009, 1'b0);
        bus_write(1'b0, A_IRQ_STATUS, 32'h0000_0001, 1'b0);
        bus_read(1'b0, A_IRQ_STATUS, 32'h0000_0000, 1'b0);
        checkOutput("irq_quiet", 32'(irq0), 32'h0);

        // Two wait states
        bus_write(1'b1, A_DIR, 32'h0000_1234, 1'b0);
        checkOutput("ws2_gpio_oe", 32'(gpio_oe2), 32'h0000_1234);
        bus_read(1'b1, A_DIR, 32'h0000_1234, 1'b0);
        bus_read(1'b1, 12'h024, 32'h0, 1'b1);

        // Reset pulsed in the middle of a DATA_OUT write
        paddr   = A_DATA_OUT;
        pwrite  = 1'b1;
        pwdata  = 32'h0000_FFFF;
        psel0   = 1'b1;
        penable = 1'b0;
        @(posedge PCLK); #1;
        penable = 1'b1;
        #2;
        PRESETn = 1'b0;
        #1;
        checkOutput("midrst_gpio_out", 32'(gpio_out0), 32'h0);
        checkOutput("midrst_gpio_oe",  32'(gpio_oe0),  32'h0);
        checkOutput("midrst_pready",   32'(pready0),   32'h0);
        checkOutput("midrst_prdata",   prdata0,        32'h0);
        checkOutput("midrst_irq",      32'(irq0),      32'h0);
        psel0   = 1'b0;
        penable = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        checkOutput("postrst_gpio_out", 32'(gpio_out0), 32'h0);
        bus_read(1'b0, A_DATA_OUT, 32'h0, 1'b0);
        bus_read(1'b0, A_IRQ_STATUS, 32'h0000_FFFF, 1'b0);
        bus_read(1'b1, A_DIR, 32'h0, 1'b0);

        repeat (2) @(posedge PCLK);
        #1;
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
